// File: rtl/abs_diff_err_sweep.sv
// abs_diff_err_sweep: exhaustive-sweep error evaluator for approximate |a-b| circuits
// Drives every input vector, samples the combinational outputs, and accumulates max/sum/violation counts.
module abs_diff_err_sweep #(
    parameter int          N_IN  = 4,
    parameter int          N_OUT = 3,
    parameter int unsigned ET    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [N_IN-1:0]       vec,
    input  logic [N_OUT-1:0]      approx,
    output logic                  busy,
    output logic                  done,
    output logic [N_OUT-1:0]      max_err,
    output logic [N_IN+N_OUT-1:0] sum_err,
    output logic [N_IN:0]         err_cnt,
    output logic                  pass
);
    localparam int W = N_IN / 2;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
    state_t state, state_nx;

    logic                 go;
    logic                 s1_valid;
    logic [N_IN-1:0]      s1_vec;
    logic [N_OUT-1:0]     s1_approx;
    logic [W-1:0]         op_a, op_b, diff;
    logic [N_OUT-1:0]     exact, err;
    logic                 viol;

    assign go = start && (state == IDLE || state == DONE);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = start ? SWEEP : state;
            SWEEP:      state_nx = (vec == '1) ? DRAIN : SWEEP;
            DRAIN:      state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    // Stage 2 error computation from the stage-1 capture
    assign op_a  = s1_vec[W-1:0];
    assign op_b  = s1_vec[N_IN-1:W];
    assign diff  = (op_a >= op_b) ? op_a - op_b : op_b - op_a;
    assign exact = N_OUT'(diff);
    assign err   = (exact >= s1_approx) ? exact - s1_approx : s1_approx - exact;
    assign viol  = 32'(err) > ET;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            vec       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            s1_valid  <= 1'b0;
            s1_vec    <= '0;
            s1_approx <= '0;
            max_err   <= '0;
            sum_err   <= '0;
            err_cnt   <= '0;
        end else begin
            s1_valid  <= state == SWEEP;
            s1_vec    <= vec;
            s1_approx <= approx;
            if (go) begin
                vec     <= '0;
                busy    <= 1'b1;
                done    <= 1'b0;
                max_err <= '0;
                sum_err <= '0;
                err_cnt <= '0;
            end else begin
                if (state == SWEEP) vec <= vec + N_IN'(1);
                if (state == DONE) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                if (s1_valid) begin
                    max_err <= (err > max_err) ? err : max_err;
                    sum_err <= sum_err + (N_IN+N_OUT)'(err);
                    err_cnt <= err_cnt + (N_IN+1)'(viol);
                end
            end
        end

    assign pass = done && (err_cnt == '0);
endmodule

// File: tb/tb_abs_diff_err_sweep.sv
// tb_abs_diff_err_sweep: directed checks of abs_diff_err_sweep with hand-computed totals
// A second instance with ET=2 shares the stimulus to check the threshold boundary.
module tb_abs_diff_err_sweep;
    logic       clk, rst_n, start;
    logic [3:0] vec, vec2;
    logic [2:0] approx;
    logic       busy, done, pass, busy2, done2, pass2;
    logic [2:0] max_err, max2;
    logic [6:0] sum_err, sum2;
    logic [4:0] err_cnt, cnt2;
    int         mode;
    int         n_asserts = 0;
    int         n_fail = 0;

    abs_diff_err_sweep dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec(vec), .approx(approx),
        .busy(busy), .done(done), .max_err(max_err), .sum_err(sum_err),
        .err_cnt(err_cnt), .pass(pass)
    );

    abs_diff_err_sweep #(.N_IN(4), .N_OUT(3), .ET(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .vec(vec2), .approx(approx),
        .busy(busy2), .done(done2), .max_err(max2), .sum_err(sum2),
        .err_cnt(cnt2), .pass(pass2)
    );

    // Approximate-circuit stand-ins: 0 exact, 1 const 3, 2 const 0, 3 exact except vector 5 -> 7
    function automatic logic [2:0] model(input logic [3:0] v, input int m);
        int a, b, d;
        a = int'(v[1:0]);
        b = int'(v[3:2]);
        d = (a > b) ? a - b : b - a;
        if (m == 1) return 3'd3;
        if (m == 2) return 3'd0;
        if (m == 3 && v == 4'd5) return 3'd7;
        return 3'(d);
    endfunction

    assign approx = model(vec, mode);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_vec"}, vec, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_max"}, max_err, 0);
        chk({tag, "_sum"}, sum_err, 0);
        chk({tag, "_cnt"}, err_cnt, 0);
        chk({tag, "_pass"}, pass, 0);
    endtask

    task automatic chk_res(input string tag, input int m, input int s, input int c, input int p);
        chk({tag, "_max"}, max_err, m);
        chk({tag, "_sum"}, sum_err, s);
        chk({tag, "_cnt"}, err_cnt, c);
        chk({tag, "_pass"}, pass, p);
    endtask

    // Start at E0, walk vec through every cycle, optionally poke start in SWEEP and DRAIN
    task automatic run_sweep(input string tag, input bit poke);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk({tag, "_busy_e0"}, busy, 1);
        for (int k = 0; k < 18; k++) begin
            chk($sformatf("%s_vec%0d", tag, k), vec, (k < 16) ? k : 0);
            chk($sformatf("%s_done%0d", tag, k), done, 0);
            start = poke && (k == 5 || k == 16);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        chk({tag, "_done_e18"}, done, 1);
        chk({tag, "_busy_e18"}, busy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        #3 chk_reset("por");
        @(negedge clk) rst_n = 1'b1;

        mode = 0;
        run_sweep("exact", 0);
        chk_res("exact", 0, 0, 0, 1);

        mode = 1;
        run_sweep("const3", 0);
        chk_res("const3", 3, 28, 0, 1);
        chk("et2_cnt", cnt2, 4);
        chk("et2_pass", pass2, 0);
        chk("et2_sum", sum2, 28);

        mode = 2;
        run_sweep("zero_poke", 1);
        chk_res("zero_poke", 3, 20, 0, 1);
        repeat (3) @(posedge clk);
        #1 chk("zero_hold_sum", sum_err, 20);
        chk("zero_hold_done", done, 1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("restart_done", done, 0);
        chk("restart_busy", busy, 1);
        chk("restart_sum", sum_err, 0);
        chk("restart_max", max_err, 0);
        chk("restart_vec", vec, 0);
        repeat (18) @(posedge clk);
        #1 chk("restart_done_e18", done, 1);
        chk_res("restart", 3, 20, 0, 1);

        mode = 3;
        run_sweep("single", 0);
        chk_res("single", 7, 7, 1, 0);

        mode = 1;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 chk("abort_vec9", vec, 9);
        #2 rst_n = 1'b0;
        #1 chk_reset("abort");
        @(negedge clk) rst_n = 1'b1;
        run_sweep("after_abort", 0);
        chk_res("after_abort", 3, 28, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
